// File: rtl/vm2002_common_pkg.sv
// ---------------------------------------------------------------------------
// vm2002_common_pkg
// Shared types and constants for the VM2002 vending controller:
//   coins_t      - coin encoding on the coin / change_coin buses
//   status_t     - customer-visible status code
//   state_idx_t  - FSM state index (bit position in the one-hot state)
//   state_oh_t   - one-hot FSM state as driven on the state output
//   coin values  - coin worth in nickel units, plus a lookup function
// ---------------------------------------------------------------------------
package vm2002_common_pkg;

    typedef enum logic [1:0] {
        NO_COINS = 2'd0,
        NICKEL   = 2'd1,
        DIME     = 2'd2,
        QUARTER  = 2'd3
    } coins_t;

    typedef enum logic [1:0] {
        NO_STATUS    = 2'd0,
        AVAILABLE    = 2'd1,
        OUT_OF_STOCK = 2'd2,
        ERROR        = 2'd3
    } status_t;

    typedef enum logic [2:0] {
        IDLE_IDX             = 3'd0,
        RESTOCK_IDX          = 3'd1,
        CHECK_ITEM_COUNT_IDX = 3'd2,
        INSERT_COINS_IDX     = 3'd3,
        CHECK_BALANCE_IDX    = 3'd4,
        DISPENSE_ITEM_IDX    = 3'd5,
        RETURN_CHANGE_IDX    = 3'd6
    } state_idx_t;

    typedef enum logic [6:0] {
        ST_IDLE             = 7'b000_0001,
        ST_RESTOCK          = 7'b000_0010,
        ST_CHECK_ITEM_COUNT = 7'b000_0100,
        ST_INSERT_COINS     = 7'b000_1000,
        ST_CHECK_BALANCE    = 7'b001_0000,
        ST_DISPENSE_ITEM    = 7'b010_0000,
        ST_RETURN_CHANGE    = 7'b100_0000
    } state_oh_t;

    // Coin worth in nickel units
    localparam logic [2:0] NICKEL_VAL  = 3'd1;
    localparam logic [2:0] DIME_VAL    = 3'd2;
    localparam logic [2:0] QUARTER_VAL = 3'd5;

    function automatic logic [2:0] coin_value(input coins_t c);
        logic [2:0] v;
        case (c)
            NICKEL:  v = NICKEL_VAL;
            DIME:    v = DIME_VAL;
            QUARTER: v = QUARTER_VAL;
            default: v = 3'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vm2002_change_gen.sv
// ---------------------------------------------------------------------------
// vm2002_change_gen
// Picks the next change coin for a given balance: the largest coin whose
// value does not exceed the balance.  Purely combinational; the controller
// registers the chosen coin and subtracts its value each cycle.
// Ports:
//   i_balance - remaining balance in nickel units
//   o_coin    - coin to emit next (NO_COINS when balance is zero)
//   o_valid   - a coin is available (balance non-zero)
//   o_done    - nothing left to return (balance zero)
// ---------------------------------------------------------------------------
module vm2002_change_gen
    import vm2002_common_pkg::*;
#(
    parameter int AMOUNT_W = 8
) (
    input  logic [AMOUNT_W-1:0] i_balance,
    output coins_t              o_coin,
    output logic                o_valid,
    output logic                o_done
);

    // Greedy coin choice, largest denomination first
    always_comb begin
        o_coin = NO_COINS;
        if (i_balance >= AMOUNT_W'(QUARTER_VAL)) begin
            o_coin = QUARTER;
        end else if (i_balance >= AMOUNT_W'(DIME_VAL)) begin
            o_coin = DIME;
        end else if (i_balance >= AMOUNT_W'(NICKEL_VAL)) begin
            o_coin = NICKEL;
        end else begin
            o_coin = NO_COINS;
        end
    end

    assign o_valid = (i_balance != '0);
    assign o_done  = (i_balance == '0);

endmodule

// File: rtl/vm2002_vend_ctrl.sv
// ---------------------------------------------------------------------------
// vm2002_vend_ctrl
// Vending machine controller: accepts coins, item selection, cancel and
// restock requests; tracks per-item stock and the customer balance;
// dispenses items and optionally returns change coin by coin.
//
// Optional feature macro: VM2002_CHANGE_RETURN_EN
//   defined   - RETURN_CHANGE pays the balance out one coin per cycle
//   undefined - RETURN_CHANGE keeps the balance as credit for the next sale
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   coin_valid, coin      - coin insertion strobe and denomination
//   select_valid, select  - item selection strobe and index (1..NUM_ITEMS)
//   cancel                - abort while waiting for coins
//   restock, restock_item, restock_qty - add stock to one item
//   state                 - one-hot FSM state
//   balance               - current balance in nickel units
//   status                - last status code (held until next accepted
//                           select or restock)
//   coin_reject           - one-cycle pulse, coin not accepted
//   dispense_valid/_item  - one-cycle dispense strobe with item index
//   change_valid/_coin    - change coin strobe and denomination
// ---------------------------------------------------------------------------
module vm2002_vend_ctrl
    import vm2002_common_pkg::*;
#(
    parameter int                          NUM_ITEMS   = 7,
    parameter int                          COUNT_W     = 4,
    parameter int                          AMOUNT_W    = 8,
    parameter int                          INIT_COUNT  = 8,
    parameter int                          TIMEOUT_CYC = 1000,
    // Item i occupies bits [(i-1)*AMOUNT_W +: AMOUNT_W]
    parameter logic [NUM_ITEMS*AMOUNT_W-1:0] COST =
        {8'd30, 8'd25, 8'd40, 8'd20, 8'd20, 8'd20, 8'd10},
    localparam int                         SEL_W = $clog2(NUM_ITEMS + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_valid,
    input  coins_t              coin,
    input  logic                select_valid,
    input  logic [SEL_W-1:0]    select,
    input  logic                cancel,
    input  logic                restock,
    input  logic [SEL_W-1:0]    restock_item,
    input  logic [COUNT_W-1:0]  restock_qty,
    output logic [6:0]          state,
    output logic [AMOUNT_W-1:0] balance,
    output status_t             status,
    output logic                coin_reject,
    output logic                dispense_valid,
    output logic [SEL_W-1:0]    dispense_item,
    output logic                change_valid,
    output coins_t              change_coin
);

    localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    state_oh_t           r_state;
    logic [AMOUNT_W-1:0] r_balance;
    status_t             r_status;
    logic                r_coin_reject;
    logic                r_dispense_valid;
    logic [SEL_W-1:0]    r_dispense_item;
    logic                r_change_valid;
    coins_t              r_change_coin;
    logic [SEL_W-1:0]    r_item;
    logic [SEL_W-1:0]    r_rs_item;
    logic [COUNT_W-1:0]  r_rs_qty;
    logic [COUNT_W-1:0]  r_count [1:NUM_ITEMS];
    logic [TMR_W-1:0]    r_timer;

    logic [2:0]          w_coin_val;
    logic                w_coin_present;
    logic [AMOUNT_W:0]   w_sum;
    logic                w_coin_fits;
    logic                w_coin_accept;
    logic                w_sel_valid;
    logic                w_rs_valid;
    logic [AMOUNT_W-1:0] w_cost;
    logic [COUNT_W-1:0]  w_item_cnt;
    logic [COUNT_W-1:0]  w_rs_cnt;
    logic [COUNT_W:0]    w_rs_sum;
    logic [COUNT_W-1:0]  w_rs_new;
    logic                w_timeout;

    assign w_coin_val     = coin_value(coin);
    assign w_coin_present = coin_valid && (coin != NO_COINS);
    // One extra bit catches a coin that would overflow the balance
    assign w_sum          = {1'b0, r_balance} + (AMOUNT_W+1)'(w_coin_val);
    assign w_coin_fits    = !w_sum[AMOUNT_W];
    // Cancel takes priority over a coin presented in the same cycle
    assign w_coin_accept  = w_coin_present && w_coin_fits &&
                            ((r_state == ST_IDLE) ||
                             ((r_state == ST_INSERT_COINS) && !cancel));
    assign w_sel_valid    = (int'(select) >= 1) && (int'(select) <= NUM_ITEMS);
    assign w_rs_valid     = (int'(r_rs_item) >= 1) && (int'(r_rs_item) <= NUM_ITEMS);
    assign w_timeout      = (r_timer == TMR_W'(TIMEOUT_CYC - 1));

    // Price and stock of the latched item, stock of the restock target
    always_comb begin
        w_cost     = '0;
        w_item_cnt = '0;
        w_rs_cnt   = '0;
        for (int i = 1; i <= NUM_ITEMS; i++) begin
            w_cost     = (r_item == SEL_W'(i)) ? COST[(i-1)*AMOUNT_W +: AMOUNT_W] : w_cost;
            w_item_cnt = (r_item == SEL_W'(i)) ? r_count[i] : w_item_cnt;
            w_rs_cnt   = (r_rs_item == SEL_W'(i)) ? r_count[i] : w_rs_cnt;
        end
    end

    // Restocked count saturates at the counter maximum
    assign w_rs_sum = {1'b0, w_rs_cnt} + {1'b0, r_rs_qty};
    assign w_rs_new = w_rs_sum[COUNT_W] ? {COUNT_W{1'b1}} : w_rs_sum[COUNT_W-1:0];

`ifdef VM2002_CHANGE_RETURN_EN
    coins_t w_chg_coin;
    logic   w_chg_valid;
    logic   w_chg_done;

    vm2002_change_gen #(
        .AMOUNT_W (AMOUNT_W)
    ) u_change_gen (
        .i_balance (r_balance),
        .o_coin    (w_chg_coin),
        .o_valid   (w_chg_valid),
        .o_done    (w_chg_done)
    );
`endif

    // Main controller FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_balance        <= '0;
            r_status         <= NO_STATUS;
            r_coin_reject    <= 1'b0;
            r_dispense_valid <= 1'b0;
            r_dispense_item  <= '0;
            r_change_valid   <= 1'b0;
            r_change_coin    <= NO_COINS;
            r_item           <= '0;
            r_rs_item        <= '0;
            r_rs_qty         <= '0;
            r_timer          <= '0;
            for (int i = 1; i <= NUM_ITEMS; i++) begin
                r_count[i] <= COUNT_W'(INIT_COUNT);
            end
        end else begin
            r_coin_reject    <= w_coin_present && !w_coin_accept;
            r_dispense_valid <= 1'b0;
            r_change_valid   <= 1'b0;
            r_change_coin    <= NO_COINS;
            if (w_coin_accept) begin
                r_balance <= w_sum[AMOUNT_W-1:0];
            end

            case (r_state)
                ST_IDLE: begin
                    if (restock) begin
                        r_rs_item <= restock_item;
                        r_rs_qty  <= restock_qty;
                        r_status  <= NO_STATUS;
                        r_state   <= ST_RESTOCK;
                    end else if (select_valid) begin
                        if (w_sel_valid) begin
                            r_item   <= select;
                            r_status <= NO_STATUS;
                            r_state  <= ST_CHECK_ITEM_COUNT;
                        end else begin
                            r_status <= ERROR;
                        end
                    end
                end

                ST_RESTOCK: begin
                    if (w_rs_valid) begin
                        for (int i = 1; i <= NUM_ITEMS; i++) begin
                            if (r_rs_item == SEL_W'(i)) begin
                                r_count[i] <= w_rs_new;
                            end
                        end
                    end else begin
                        r_status <= ERROR;
                    end
                    r_state <= ST_IDLE;
                end

                ST_CHECK_ITEM_COUNT: begin
                    if (w_item_cnt == '0) begin
                        r_status <= OUT_OF_STOCK;
                        r_state  <= ST_RETURN_CHANGE;
                    end else begin
                        r_status <= AVAILABLE;
                        r_state  <= ST_CHECK_BALANCE;
                    end
                end

                ST_CHECK_BALANCE: begin
                    if (r_balance >= w_cost) begin
                        // Strobe rises together with the DISPENSE_ITEM state
                        r_dispense_valid <= 1'b1;
                        r_dispense_item  <= r_item;
                        r_state          <= ST_DISPENSE_ITEM;
                    end else begin
                        r_timer <= '0;
                        r_state <= ST_INSERT_COINS;
                    end
                end

                ST_INSERT_COINS: begin
                    if (cancel) begin
                        r_state <= ST_RETURN_CHANGE;
                    end else if (w_coin_accept) begin
                        r_state <= ST_CHECK_BALANCE;
                    end else if (w_timeout) begin
                        r_state <= ST_RETURN_CHANGE;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end

                ST_DISPENSE_ITEM: begin
                    for (int i = 1; i <= NUM_ITEMS; i++) begin
                        if (r_item == SEL_W'(i)) begin
                            r_count[i] <= r_count[i] - COUNT_W'(1);
                        end
                    end
                    r_balance <= r_balance - w_cost;
                    r_state   <= ST_RETURN_CHANGE;
                end

                ST_RETURN_CHANGE: begin
`ifdef VM2002_CHANGE_RETURN_EN
                    if (w_chg_done) begin
                        r_state <= ST_IDLE;
                    end else if (w_chg_valid) begin
                        r_change_valid <= 1'b1;
                        r_change_coin  <= w_chg_coin;
                        r_balance      <= r_balance - AMOUNT_W'(coin_value(w_chg_coin));
                    end else begin
                        r_state <= ST_IDLE;
                    end
`else
                    // Balance stays as credit for the next purchase
                    r_state <= ST_IDLE;
`endif
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign state          = r_state;
    assign balance        = r_balance;
    assign status         = r_status;
    assign coin_reject    = r_coin_reject;
    assign dispense_valid = r_dispense_valid;
    assign dispense_item  = r_dispense_item;
    assign change_valid   = r_change_valid;
    assign change_coin    = r_change_coin;

endmodule

// File: tb/tb_vm2002_vend_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vm2002_vend_ctrl
// Directed stimulus for vm2002_vend_ctrl.  Expected output events
// (dispense, change coin, coin reject) are queued by the stimulus and
// consumed by a monitor that fires whenever the DUT raises one of them.
// Expectations follow VM2002_CHANGE_RETURN_EN when it is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vm2002_vend_ctrl;
    import vm2002_common_pkg::*;

    localparam int T_CYC = 50;

    localparam logic [2:0] K_DISP = 3'b100;
    localparam logic [2:0] K_CHG  = 3'b010;
    localparam logic [2:0] K_REJ  = 3'b001;

    typedef struct {
        logic [2:0] kind;
        logic [3:0] data;
        logic       chk_bal;
        logic [7:0] bal;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        coin_valid;
    coins_t      coin;
    logic        select_valid;
    logic [2:0]  select;
    logic        cancel;
    logic        restock;
    logic [2:0]  restock_item;
    logic [3:0]  restock_qty;
    logic [6:0]  state;
    logic [7:0]  balance;
    status_t     status;
    logic        coin_reject;
    logic        dispense_valid;
    logic [2:0]  dispense_item;
    logic        change_valid;
    coins_t      change_coin;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    logic [2:0] mon_obs;
    logic [3:0] mon_data;

    vm2002_vend_ctrl #(
        .TIMEOUT_CYC (T_CYC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .coin_valid     (coin_valid),
        .coin           (coin),
        .select_valid   (select_valid),
        .select         (select),
        .cancel         (cancel),
        .restock        (restock),
        .restock_item   (restock_item),
        .restock_qty    (restock_qty),
        .state          (state),
        .balance        (balance),
        .status         (status),
        .coin_reject    (coin_reject),
        .dispense_valid (dispense_valid),
        .dispense_item  (dispense_item),
        .change_valid   (change_valid),
        .change_coin    (change_coin)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: every output event must match the head of the scoreboard
    always @(negedge clk) begin
        mon_obs = {dispense_valid, change_valid, coin_reject};
        if ((|mon_obs) === 1'b1) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_event: got kind=%b item=%0d coin=%0d bal=%0d, required no event",
                         mon_obs, dispense_item, change_coin, balance);
            end else begin
                mon_e    = sb_q.pop_front();
                mon_data = dispense_valid ? {1'b0, dispense_item} : {2'b00, change_coin};
                if (mon_obs !== mon_e.kind ||
                    (mon_e.kind != K_REJ && mon_data !== mon_e.data) ||
                    (mon_e.chk_bal && balance !== mon_e.bal)) begin
                    n_errors++;
                    $display("FAIL event: got kind=%b data=%0d bal=%0d, required kind=%b data=%0d bal=%0d",
                             mon_obs, mon_data, balance, mon_e.kind, mon_e.data, mon_e.bal);
                end
            end
        end
    end

    function void push(input logic [2:0] k, input logic [3:0] d, input logic cb, input logic [7:0] b);
        exp_t e;
        e.kind = k; e.data = d; e.chk_bal = cb; e.bal = b;
        sb_q.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic wait_state(input logic [6:0] st, input int budget);
        int k = 0;
        while (state !== st && k < budget) begin
            tick();
            k++;
        end
        if (state !== st) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_state: got state %b, required %b within %0d cycles", state, st, budget);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic do_select(input logic [2:0] item);
        select_valid = 1'b1;
        select       = item;
        tick();
        select_valid = 1'b0;
        select       = 3'd0;
    endtask

    task automatic drive_coin(input coins_t c);
        coin_valid = 1'b1;
        coin       = c;
        tick();
        coin_valid = 1'b0;
        coin       = NO_COINS;
    endtask

    task automatic insert_wait(input coins_t c);
        wait_state(ST_INSERT_COINS, 20);
        drive_coin(c);
    endtask

    task automatic do_restock(input logic [2:0] item, input logic [3:0] qty);
        restock      = 1'b1;
        restock_item = item;
        restock_qty  = qty;
        tick();
        restock      = 1'b0;
        wait_state(ST_IDLE, 10);
    endtask

    initial begin
        int n;
        int b;
        coins_t c;
        reset = 1'b1; coin_valid = 1'b0; coin = NO_COINS; select_valid = 1'b0;
        select = 3'd0; cancel = 1'b0; restock = 1'b0; restock_item = 3'd0;
        restock_qty = 4'd0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_state",          state, ST_IDLE);
        check("rst_balance",        balance, 0);
        check("rst_status",         status, NO_STATUS);
        check("rst_dispense_valid", dispense_valid, 0);
        check("rst_change_valid",   change_valid, 0);
        check("rst_change_coin",    change_coin, NO_COINS);
        check("rst_coin_reject",    coin_reject, 0);

        // Item 1 (cost 10) paid exactly with two quarters
        push(K_DISP, 4'd1, 1'b0, 8'd0);
        do_select(3'd1);
        insert_wait(QUARTER);
        insert_wait(QUARTER);
        wait_state(ST_IDLE, 20);
        check("buy1_balance", balance, 0);
        check("buy1_status",  status, AVAILABLE);

        // Item 1 paid with Q,D,Q = 12 units; 2 units left over
        push(K_DISP, 4'd1, 1'b0, 8'd0);
`ifdef VM2002_CHANGE_RETURN_EN
        push(K_CHG, {2'b00, DIME}, 1'b1, 8'd0);
`endif
        do_select(3'd1);
        insert_wait(QUARTER);
        insert_wait(DIME);
        insert_wait(QUARTER);
        wait_state(ST_IDLE, 20);
`ifdef VM2002_CHANGE_RETURN_EN
        check("buy2_balance", balance, 0);
`else
        check("buy2_balance", balance, 2);
`endif

        // Reset discards any credit
        do_reset();
        check("rst2_balance", balance, 0);
        check("rst2_state",   state, ST_IDLE);

        // Restock item 2 by 15 from 8: saturates at 15; item 0 is an error
        do_restock(3'd2, 4'd15);
        check("restock_status", status, NO_STATUS);
        do_restock(3'd0, 4'd3);
        check("restock0_status", status, ERROR);
        for (int i = 0; i < 15; i++) begin
            push(K_DISP, 4'd2, 1'b0, 8'd0);
            do_select(3'd2);
            for (int q = 0; q < 4; q++) insert_wait(QUARTER);
            wait_state(ST_IDLE, 20);
        end
        check("item2_15_status",  status, AVAILABLE);
        check("item2_15_balance", balance, 0);
        do_select(3'd2);
        wait_state(ST_IDLE, 10);
        check("item2_16_status", status, OUT_OF_STOCK);
        do_select(3'd0);
        check("sel0_status", status, ERROR);
        check("sel0_state",  state, ST_IDLE);

        // Nine purchases of item 1 from a fresh stock of 8
        do_reset();
        for (int i = 0; i < 8; i++) begin
            push(K_DISP, 4'd1, 1'b0, 8'd0);
            do_select(3'd1);
            insert_wait(QUARTER);
            insert_wait(QUARTER);
            wait_state(ST_IDLE, 20);
        end
`ifdef VM2002_CHANGE_RETURN_EN
        push(K_CHG, {2'b00, NICKEL}, 1'b1, 8'd0);
`endif
        drive_coin(NICKEL);
        check("oos_prepay_balance", balance, 1);
        do_select(3'd1);
        wait_state(ST_IDLE, 10);
        check("oos_status", status, OUT_OF_STOCK);
`ifdef VM2002_CHANGE_RETURN_EN
        check("oos_balance", balance, 0);
`else
        check("oos_balance", balance, 1);
`endif

        // Timeout after exactly T_CYC cycles waiting for coins
        do_reset();
`ifdef VM2002_CHANGE_RETURN_EN
        push(K_CHG, {2'b00, NICKEL}, 1'b1, 8'd0);
`endif
        do_select(3'd3);
        insert_wait(NICKEL);
        wait_state(ST_INSERT_COINS, 10);
        n = 0;
        while (state === ST_INSERT_COINS && n < T_CYC + 10) begin
            n++;
            tick();
        end
        check("timeout_cycles", n, T_CYC);
        check("timeout_state",  state, ST_RETURN_CHANGE);
        wait_state(ST_IDLE, 10);
`ifdef VM2002_CHANGE_RETURN_EN
        b = 0;
`else
        b = 1;
`endif
        check("timeout_balance", balance, b);

        // Cancel and coin in the same cycle: cancel wins, coin rejected
        do_select(3'd3);
        wait_state(ST_INSERT_COINS, 10);
        push(K_REJ, 4'd0, 1'b1, 8'(b));
        cancel     = 1'b1;
        coin_valid = 1'b1;
        coin       = DIME;
        tick();
        cancel     = 1'b0;
        coin_valid = 1'b0;
        coin       = NO_COINS;
        check("cancel_state", state, ST_RETURN_CHANGE);
        wait_state(ST_IDLE, 10);
        check("cancel_balance", balance, b);

        // Build balance 253, then a quarter overflows and is rejected
        do_reset();
        coin_valid = 1'b1;
        coin       = QUARTER;
        repeat (50) tick();
        coin = DIME;
        tick();
        coin = NICKEL;
        tick();
        check("bal253", balance, 253);
        push(K_REJ, 4'd0, 1'b1, 8'd253);
        coin = QUARTER;
        tick();
        coin_valid = 1'b0;
        coin       = NO_COINS;
        tick();
        check("overflow_balance", balance, 253);

        // Item 7 (cost 30) bought straight from the 253 balance
        push(K_DISP, 4'd7, 1'b0, 8'd0);
`ifdef VM2002_CHANGE_RETURN_EN
        b = 223;
        while (b > 0) begin
            c = (b >= 5) ? QUARTER : ((b >= 2) ? DIME : NICKEL);
            b = b - int'(coin_value(c));
            push(K_CHG, {2'b00, c}, 1'b1, 8'(b));
        end
`endif
        do_select(3'd7);
        wait_state(ST_IDLE, 80);
`ifdef VM2002_CHANGE_RETURN_EN
        check("buy7_balance", balance, 0);
`else
        check("buy7_balance", balance, 223);
`endif

        // Reset while waiting for coins discards the balance, no change
        do_reset();
        drive_coin(NICKEL);
        do_select(3'd5);
        wait_state(ST_INSERT_COINS, 10);
        check("pre_rst_balance", balance, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_state",   state, ST_IDLE);
        check("midrst_balance", balance, 0);
        repeat (5) tick();

        check("scoreboard_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
